spi_master_fifo: RTL

//  Generalised SPI transmit master with an input FIFO. Display drivers and other peripheral

---
 rtl/spi_master_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - SPI transmit master with input FIFO, run-time CPOL/CPHA and per-word DC
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          dc_i,
    input  logic [1:0]                    mode_i,
    output logic                          sda_o,
    output logic                          scl_o,
    output logic                          dc_o,
    output logic                          cs_no,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(DATA_W - 1);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_q;
    logic              push, pop;
    logic [DATA_W:0]   head;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [1:0]        mode_q, mode_d;
    logic              scl_q, scl_d, sda_q, sda_d, dc_q, dc_d, cs_q, cs_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              load;
    logic [1:0]        start_mode;

    assign push    = valid_i & ready_o;
    assign pop     = load;
    assign head    = mem[rd_ptr];
    assign ready_o = (level_q != FULL);
    assign level_o = level_q;
    assign shifted = shreg_q << 1;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {dc_i, data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A word launched from idle uses the live mode; back-to-back words keep the burst's mode.
    assign start_mode = cs_q ? mode_i : mode_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        dc_d    = dc_q;
        cs_d    = cs_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_q) begin
                    mode_d = mode_i;
                    scl_d  = mode_i[1];
                    if (pend_q) begin
                        pend_d = 1'b0;
                        load   = 1'b1;
                    end else if (level_q != '0) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    // One closing cycle after the last bit period before deselecting.
                    cs_d = 1'b1;
                end
            end
            LEAD: begin
                if (cnt_q == '0) begin
                    scl_d   = ~scl_q;
                    cnt_d   = CNT_LOAD;
                    state_d = TRAIL;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TRAIL: begin
                if (cnt_q == '0) begin
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BW'(1);
                        shreg_d = shifted;
                        sda_d   = shifted[DATA_W-1];
                        scl_d   = mode_q[1] ^ mode_q[0];
                        cnt_d   = CNT_LOAD;
                        state_d = LEAD;
                    end else if (level_q != '0) begin
                        load = 1'b1;
                    end else begin
                        scl_d   = mode_q[1];
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cs_d    = 1'b0;
            dc_d    = head[DATA_W];
            shreg_d = head[DATA_W-1:0];
            sda_d   = head[DATA_W-1];
            bit_d   = BIT_LOAD;
            cnt_d   = CNT_LOAD;
            scl_d   = start_mode[1] ^ start_mode[0];
            state_d = LEAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            mode_q  <= 2'b10;
            scl_q   <= 1'b1;
            sda_q   <= 1'b0;
            dc_q    <= 1'b0;
            cs_q    <= 1'b1;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            dc_q    <= dc_d;
            cs_q    <= cs_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign sda_o  = sda_q;
    assign scl_o  = scl_q;
    assign dc_o   = dc_q;
    assign cs_no  = cs_q;
    assign busy_o = (level_q != '0) | ~cs_q;

endmodule
